// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared CPU types used by the memory arbiter and the blocks around it.
//   Contents:
//     word_t          - 32-bit machine word
//     ramstate_t      - status reported by the RAM model/bus
//     arbstate_t      - arbiter FSM states
//     ARB_MAX_DSTREAK - default limit on back-to-back data grants
//     ARB_TIMEOUT     - default cycles before a stuck grant is abandoned
//     arbCountWidth() - counter width helper that never returns zero
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IXFER = 2'd1,
        ARB_DXFER = 2'd2
    } arbstate_t;

    localparam int ARB_MAX_DSTREAK = 4;
    localparam int ARB_TIMEOUT     = 64;

    // Degenerate parameter values (1 or less) would otherwise produce a
    // zero-width counter, so clamp to at least one bit.
    function automatic int arbCountWidth(input int maxVal);
        return (maxVal > 1) ? $clog2(maxVal) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// ---------------------------------------------------------------------------
// arb_timer
//   Clearable saturating counter that measures how long the current grant
//   has been waiting on the RAM. tc_o rises once the count reaches
//   TIMEOUT-1 and stays there until cleared.
//   Ports:
//     clk_i    - clock
//     rst_i    - synchronous active-high reset
//     clear_i  - force the count back to zero
//     enable_i - advance the count by one this cycle
//     tc_o     - terminal count reached
// ---------------------------------------------------------------------------
module arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int            W    = arbCountWidth(TIMEOUT);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q, count_d;

    // Clear has priority; counting stops at the terminal value so the
    // counter never wraps back to zero and hides a stuck transfer.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single-ported RAM between the instruction cache and the data
//   cache. One requester is granted at a time and keeps the grant until the
//   RAM answers ACCESS or ERROR, the grant times out, or the requester drops
//   its request. Data requests win ties, but after MAX_DSTREAK consecutive
//   data grants taken while an instruction fetch was waiting, the fetch is
//   served next.
//   Ports:
//     CLK, RST                  - clock, synchronous active-high reset
//     iREN, iaddr               - icache read request and word address
//     iwait, iload              - icache stall (low on completion), read data
//     dREN, dWEN, daddr, dstore - dcache read/write request, address, data
//     dwait, dload              - dcache stall (low on completion), read data
//     ramREN, ramWEN            - RAM read/write strobes
//     ramaddr, ramstore         - RAM address and write data
//     ramload, ramstate         - RAM read data and status
//     memerr                    - one-cycle pulse after ERROR or timeout
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DSTREAK = ARB_MAX_DSTREAK,
    parameter int TIMEOUT     = ARB_TIMEOUT
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    localparam int           SW         = arbCountWidth(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    arbstate_t     state_q, state_d;
    logic [SW-1:0] dstreak_q, dstreak_d;
    logic          memerr_q, memerr_d;

    logic dReq;
    logic inXfer;
    logic reqHeld;
    logic ramDone;
    logic timeoutHit;

    assign dReq    = dREN | dWEN;
    assign inXfer  = (state_q == ARB_IXFER) || (state_q == ARB_DXFER);
    assign reqHeld = (state_q == ARB_DXFER) ? dReq : iREN;
    assign ramDone = (ramstate == ACCESS) || (ramstate == ERROR);

    // The timer is held at zero while idle, so every grant starts counting
    // from zero in its first transfer cycle.
    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clear_i  (state_q == ARB_IDLE),
        .enable_i (inXfer && !ramDone),
        .tc_o     (timeoutHit)
    );

    // Arbitration and transfer termination. A dropped request ends the
    // transfer quietly and is checked first; otherwise ACCESS completes it
    // and ERROR or the timer abandons it with an error pulse.
    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        memerr_d  = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (dReq && !(iREN && (dstreak_q == STREAK_MAX))) begin
                    state_d = ARB_DXFER;
                    if (!iREN) begin
                        dstreak_d = '0;
                    end else if (dstreak_q != STREAK_MAX) begin
                        dstreak_d = dstreak_q + 1'b1;
                    end
                end else if (iREN) begin
                    state_d   = ARB_IXFER;
                    dstreak_d = '0;
                end
            end
            ARB_IXFER, ARB_DXFER: begin
                if (!reqHeld) begin
                    state_d = ARB_IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = ARB_IDLE;
                end else if ((ramstate == ERROR) || timeoutHit) begin
                    state_d  = ARB_IDLE;
                    memerr_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // RAM drive and stalls. Strobes follow the live request so that a
    // requester backing out mid-transfer releases the RAM in the same cycle.
    // A write wins over a read when the dcache raises both.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        unique case (state_q)
            ARB_DXFER: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = (ramstate != ACCESS);
            end
            ARB_IXFER: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = (ramstate != ACCESS);
            end
            default: begin
            end
        endcase
    end

    // State, streak counter and the registered error pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ARB_IDLE;
            dstreak_q <= '0;
            memerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            memerr_q  <= memerr_d;
        end
    end

    assign memerr = memerr_q;
    assign iload  = ramload;
    assign dload  = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed cycle tables for the
//   documented scenarios, then randomized traffic against a transaction-level
//   reference model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAXD = 4;
    localparam int TOUT = 64;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN, memerr;
    word_t     iload, dload, ramaddr, ramstore;

    int nCompared;
    int nMismatched;

    // One cycle of stimulus together with the outputs expected in that cycle.
    typedef struct {
        string     nm;
        logic      chk;
        logic      rst, iren, dren, dwen;
        word_t     iaddr, daddr, dstore, ramload;
        ramstate_t rs;
        logic      eREN, eWEN;
        word_t     eAddr, eStore;
        logic      eIwait, eDwait, eMemerr;
    } vec_t;

    vec_t vecs[$];

    mem_arbiter #(
        .MAX_DSTREAK (MAXD),
        .TIMEOUT     (TOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mkVec(input string nm, input int chk, input int rst,
                                   input int iren, input int dren, input int dwen,
                                   input word_t ia, input word_t da, input word_t ds,
                                   input word_t rl, input ramstate_t rs,
                                   input int eREN, input int eWEN,
                                   input word_t eAddr, input word_t eStore,
                                   input int eIwait, input int eDwait, input int eMemerr);
        vec_t v;
        v.nm      = nm;
        v.chk     = (chk != 0);
        v.rst     = (rst != 0);
        v.iren    = (iren != 0);
        v.dren    = (dren != 0);
        v.dwen    = (dwen != 0);
        v.iaddr   = ia;
        v.daddr   = da;
        v.dstore  = ds;
        v.ramload = rl;
        v.rs      = rs;
        v.eREN    = (eREN != 0);
        v.eWEN    = (eWEN != 0);
        v.eAddr   = eAddr;
        v.eStore  = eStore;
        v.eIwait  = (eIwait != 0);
        v.eDwait  = (eDwait != 0);
        v.eMemerr = (eMemerr != 0);
        return v;
    endfunction

    task automatic checkWord(input string nm, input word_t act, input word_t exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkBit(input string nm, input logic act, input logic exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        RST      = v.rst;
        iREN     = v.iren;
        dREN     = v.dren;
        dWEN     = v.dwen;
        iaddr    = v.iaddr;
        daddr    = v.daddr;
        dstore   = v.dstore;
        ramload  = v.ramload;
        ramstate = v.rs;
    endtask

    task automatic checkOutput(input vec_t v);
        checkBit ({v.nm, ".ramREN"},   ramREN,   v.eREN);
        checkBit ({v.nm, ".ramWEN"},   ramWEN,   v.eWEN);
        checkWord({v.nm, ".ramaddr"},  ramaddr,  v.eAddr);
        checkWord({v.nm, ".ramstore"}, ramstore, v.eStore);
        checkBit ({v.nm, ".iwait"},    iwait,    v.eIwait);
        checkBit ({v.nm, ".dwait"},    dwait,    v.eDwait);
        checkBit ({v.nm, ".memerr"},   memerr,   v.eMemerr);
        if (!v.eIwait) checkWord({v.nm, ".iload"}, iload, v.ramload);
        if (!v.eDwait) checkWord({v.nm, ".dload"}, dload, v.ramload);
    endtask

    // Drive just after a rising edge, sample on the falling edge.
    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(negedge CLK);
        if (v.chk) checkOutput(v);
        @(posedge CLK);
        #1;
    endtask

    task automatic buildVectors();
        // Single data read: two BUSY cycles then ACCESS.
        vecs.push_back(mkVec("rd0", 1,0, 0,1,0, 0,'h40,0,0,          FREE,   0,0,0,0,    1,1,0));
        vecs.push_back(mkVec("rd1", 1,0, 0,1,0, 0,'h40,0,0,          BUSY,   1,0,'h40,0, 1,1,0));
        vecs.push_back(mkVec("rd2", 1,0, 0,1,0, 0,'h40,0,0,          BUSY,   1,0,'h40,0, 1,1,0));
        vecs.push_back(mkVec("rd3", 1,0, 0,1,0, 0,'h40,0,'hDEADBEEF, ACCESS, 1,0,'h40,0, 1,0,0));
        vecs.push_back(mkVec("rd4", 1,0, 0,0,0, 0,'h40,0,0,          FREE,   0,0,0,0,    1,1,0));
        // Both caches at once, dcache asserting read and write.
        vecs.push_back(mkVec("both0", 1,0, 1,1,1, 'h100,'h80,'h1234,0,          FREE,   0,0,0,0,           1,1,0));
        vecs.push_back(mkVec("both1", 1,0, 1,1,1, 'h100,'h80,'h1234,'h5555,     ACCESS, 0,1,'h80,'h1234,   1,0,0));
        vecs.push_back(mkVec("both2", 1,0, 1,0,0, 'h100,'h80,'h1234,0,          FREE,   0,0,0,0,           1,1,0));
        vecs.push_back(mkVec("both3", 1,0, 1,0,0, 'h100,'h80,'h1234,0,          BUSY,   1,0,'h100,0,       1,1,0));
        vecs.push_back(mkVec("both4", 1,0, 1,0,0, 'h100,'h80,'h1234,'hCAFEF00D, ACCESS, 1,0,'h100,0,       0,1,0));
        vecs.push_back(mkVec("both5", 1,0, 0,0,0, 'h100,'h80,'h1234,0,          FREE,   0,0,0,0,           1,1,0));
        // Starvation limit: D,D,D,D then I with the RAM always answering.
        for (int k = 0; k < 12; k++) begin
            string nm;
            nm = $sformatf("starve%0d", k);
            if (k % 2 == 0)
                vecs.push_back(mkVec(nm, 1,0, 1,1,0, 'h300,'h90,0,'h77, ACCESS, 0,0,0,0,     1,1,0));
            else if (k == 9)
                vecs.push_back(mkVec(nm, 1,0, 1,1,0, 'h300,'h90,0,'h77, ACCESS, 1,0,'h300,0, 0,1,0));
            else
                vecs.push_back(mkVec(nm, 1,0, 1,1,0, 'h300,'h90,0,'h77, ACCESS, 1,0,'h90,0,  1,0,0));
        end
        vecs.push_back(mkVec("starve12", 1,0, 0,0,0, 'h300,'h90,0,0, FREE, 0,0,0,0, 1,1,0));
        // ERROR during an instruction fetch, then retry.
        vecs.push_back(mkVec("err0", 1,0, 1,0,0, 'h200,0,0,0,    FREE,   0,0,0,0,     1,1,0));
        vecs.push_back(mkVec("err1", 1,0, 1,0,0, 'h200,0,0,0,    ERROR,  1,0,'h200,0, 1,1,0));
        vecs.push_back(mkVec("err2", 1,0, 1,0,0, 'h200,0,0,0,    FREE,   0,0,0,0,     1,1,1));
        vecs.push_back(mkVec("err3", 1,0, 1,0,0, 'h200,0,0,0,    BUSY,   1,0,'h200,0, 1,1,0));
        vecs.push_back(mkVec("err4", 1,0, 1,0,0, 'h200,0,0,'h99, ACCESS, 1,0,'h200,0, 0,1,0));
        vecs.push_back(mkVec("err5", 1,0, 0,0,0, 'h200,0,0,0,    FREE,   0,0,0,0,     1,1,0));
        // Instruction request withdrawn mid-transfer.
        vecs.push_back(mkVec("abort0", 1,0, 1,0,0, 'h300,0,0,0, FREE, 0,0,0,0,     1,1,0));
        vecs.push_back(mkVec("abort1", 1,0, 1,0,0, 'h300,0,0,0, BUSY, 1,0,'h300,0, 1,1,0));
        vecs.push_back(mkVec("abort2", 1,0, 0,0,0, 'h300,0,0,0, BUSY, 0,0,'h300,0, 1,1,0));
        vecs.push_back(mkVec("abort3", 1,0, 0,0,0, 'h300,0,0,0, FREE, 0,0,0,0,     1,1,0));
        vecs.push_back(mkVec("abort4", 1,0, 0,0,0, 'h300,0,0,0, FREE, 0,0,0,0,     1,1,0));
        // RAM stuck BUSY: 64 transfer cycles, then the error pulse and a re-grant.
        vecs.push_back(mkVec("tmo0", 1,0, 0,1,0, 0,'h44,0,0, BUSY, 0,0,0,0, 1,1,0));
        for (int k = 1; k <= TOUT; k++)
            vecs.push_back(mkVec($sformatf("tmo%0d", k), 1,0, 0,1,0, 0,'h44,0,0, BUSY, 1,0,'h44,0, 1,1,0));
        vecs.push_back(mkVec("tmoErr",   1,0, 0,1,0, 0,'h44,0,0, BUSY, 0,0,0,0,    1,1,1));
        vecs.push_back(mkVec("tmoRegr",  1,0, 0,1,0, 0,'h44,0,0, BUSY, 1,0,'h44,0, 1,1,0));
        vecs.push_back(mkVec("tmoDrop",  1,0, 0,0,0, 0,'h44,0,0, BUSY, 0,0,'h44,0, 1,1,0));
        vecs.push_back(mkVec("tmoIdle",  1,0, 0,0,0, 0,'h44,0,0, FREE, 0,0,0,0,    1,1,0));
        // Reset during the fourth data grant of a streak: streak must clear,
        // so the next grant is data again rather than the waiting fetch.
        for (int k = 0; k < 7; k++) begin
            string nm;
            nm = $sformatf("rstSeq%0d", k);
            if (k % 2 == 0)
                vecs.push_back(mkVec(nm, 1,0, 1,1,1, 'h300,'h88,'hA5A5,0, ACCESS, 0,0,0,0,          1,1,0));
            else
                vecs.push_back(mkVec(nm, 1,0, 1,1,1, 'h300,'h88,'hA5A5,0, ACCESS, 0,1,'h88,'hA5A5,  1,0,0));
        end
        vecs.push_back(mkVec("rstHit",  0,1, 1,1,1, 'h300,'h88,'hA5A5,0, BUSY,   0,0,0,0,         1,1,0));
        vecs.push_back(mkVec("rstIdle", 1,0, 1,1,1, 'h300,'h88,'hA5A5,0, ACCESS, 0,0,0,0,         1,1,0));
        vecs.push_back(mkVec("rstNext", 1,0, 1,1,1, 'h300,'h88,'hA5A5,0, ACCESS, 0,1,'h88,'hA5A5, 1,0,0));
        vecs.push_back(mkVec("rstEnd",  1,0, 0,0,0, 'h300,'h88,'hA5A5,0, FREE,   0,0,0,0,         1,1,0));
    endtask

    // Randomized traffic. The reference model tracks only who owns the RAM,
    // how long the grant has lasted, the data streak and a pending error.
    task automatic runRandom(input int cycles);
        int        owner;   // 0 none, 1 icache, 2 dcache
        int        age;
        int        streak;
        bit        errPend;
        bit        iDone, dDone, canDrop, held;
        logic      iReq, dRd, dWr;
        word_t     ia, da, ds, rl;
        ramstate_t rs;
        int        r, kind;
        logic      rstNow;
        vec_t      v;
        owner = 0; age = 0; streak = 0; errPend = 1'b0;
        iDone = 1'b0; dDone = 1'b0;
        iReq = 1'b0; dRd = 1'b0; dWr = 1'b0;
        ia = '0; da = '0; ds = '0;
        for (int c = 0; c < cycles; c++) begin
            r  = int'($urandom_range(0, 99));
            rs = (r < 10) ? FREE : (r < 55) ? BUSY : (r < 88) ? ACCESS : ERROR;
            canDrop = (rs == FREE) || (rs == BUSY);
            rstNow  = ($urandom_range(0, 299) == 0);
            rl      = $urandom();
            if (iDone) begin
                iReq = ($urandom_range(0, 1) == 1);
                ia   = $urandom();
            end else if (!iReq) begin
                iReq = ($urandom_range(0, 2) == 0);
                if (iReq) ia = $urandom();
            end else if (canDrop && ($urandom_range(0, 24) == 0)) begin
                iReq = 1'b0;
            end
            if (dDone || !(dRd || dWr)) begin
                if ($urandom_range(0, 1) == 1) begin
                    kind = int'($urandom_range(0, 2));
                    dRd  = (kind != 1);
                    dWr  = (kind != 0);
                    da   = $urandom();
                    ds   = $urandom();
                end else begin
                    dRd = 1'b0;
                    dWr = 1'b0;
                end
            end else if (canDrop && ($urandom_range(0, 24) == 0)) begin
                dRd = 1'b0;
                dWr = 1'b0;
            end

            v = mkVec($sformatf("rnd%0d", c), rstNow ? 0 : 1, rstNow ? 1 : 0,
                      iReq ? 1 : 0, dRd ? 1 : 0, dWr ? 1 : 0, ia, da, ds, rl, rs,
                      0, 0, 0, 0, 1, 1, errPend ? 1 : 0);
            if (owner == 2) begin
                v.eWEN   = dWr;
                v.eREN   = dRd && !dWr;
                v.eAddr  = da;
                v.eStore = ds;
                v.eDwait = (rs != ACCESS);
            end else if (owner == 1) begin
                v.eREN   = iReq;
                v.eAddr  = ia;
                v.eIwait = (rs != ACCESS);
            end
            applyStimulus(v);
            @(negedge CLK);
            if (v.chk) checkOutput(v);
            iDone = !v.eIwait;
            dDone = !v.eDwait;

            errPend = 1'b0;
            if (rstNow) begin
                owner = 0; age = 0; streak = 0;
            end else if (owner == 0) begin
                if ((dRd || dWr) && !(iReq && streak == MAXD)) begin
                    owner  = 2;
                    age    = 0;
                    streak = iReq ? ((streak < MAXD) ? streak + 1 : streak) : 0;
                end else if (iReq) begin
                    owner  = 1;
                    age    = 0;
                    streak = 0;
                end
            end else begin
                held = (owner == 2) ? (dRd || dWr) : iReq;
                if (!held || rs == ACCESS) begin
                    owner = 0;
                end else if (rs == ERROR || age == TOUT - 1) begin
                    owner   = 0;
                    errPend = 1'b1;
                end else begin
                    age++;
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        checkBit ("reset.ramREN",   ramREN,   1'b0);
        checkBit ("reset.ramWEN",   ramWEN,   1'b0);
        checkWord("reset.ramaddr",  ramaddr,  32'h0);
        checkWord("reset.ramstore", ramstore, 32'h0);
        checkBit ("reset.iwait",    iwait,    1'b1);
        checkBit ("reset.dwait",    dwait,    1'b1);
        checkBit ("reset.memerr",   memerr,   1'b0);
        @(posedge CLK);
        #1;

        buildVectors();
        $display("[TB] running %0d directed cycles", vecs.size());
        foreach (vecs[i]) runVec(vecs[i]);

        $display("[TB] running randomized traffic");
        runVec(mkVec("rndReset", 0,1, 0,0,0, 0,0,0,0, FREE, 0,0,0,0, 1,1,0));
        runRandom(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares the single-ported RAM between the instruction cache and the data cache. It sits between both caches and the RAM model/bus and grants one requester at a time. Each grant is held until the RAM reports `ACCESS`, `ERROR` or a timeout. Data-cache requests have priority, bounded by a starvation limit that guarantees instruction fetch makes progress.

## Interface
Parameters:
- `MAX_DSTREAK`, default 4: maximum consecutive data grants while `iREN` is pending; after that the next grant goes to icache.
- `TIMEOUT`, default 64: cycles a grant may stay in `BUSY`/`FREE` before it is abandoned as an error.

Ports:
- `CLK`  in  1: clock; all state updates on rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `iREN`  in  1: icache read request.
- `iaddr`  in  32: icache word address.
- `iwait`  out  1: icache stall; low only in the icache completion cycle.
- `iload`  out  32: icache read data.
- `dREN`, `dWEN`  in  1 each: dcache read and write request.
- `daddr`, `dstore`  in  32 each: dcache address and write data.
- `dwait`  out  1: dcache stall; low only in the dcache completion cycle.
- `dload`  out  32: dcache read data.
- `ramREN`, `ramWEN`  out  1 each: RAM read and write strobes.
- `ramaddr`, `ramstore`  out  32 each: RAM address and write data.
- `ramload`  in  32: RAM read data.
- `ramstate`  in  `ramstate_t`: RAM status (`FREE`/`BUSY`/`ACCESS`/`ERROR`).
- `memerr`  out  1: one-cycle pulse when a transfer ends in `ERROR` or timeout.

## Operation
- State machine `arbstate_t`: `ARB_IDLE`, `ARB_IXFER`, `ARB_DXFER`.
- `ARB_IDLE` arbitration:
  - If `dREN|dWEN` and not (`iREN` and `dstreak==MAX_DSTREAK`): go to `ARB_DXFER`.
  - Else if `iREN`: go to `ARB_IXFER`.
  - Else stay in `ARB_IDLE`.
- `dstreak` counter:
  - Increments on each D grant made while `iREN` is high.
  - Clears on any I grant, and on a D grant made with `iREN` low.
  - Saturates at `MAX_DSTREAK`.
- `ARB_DXFER` drive:
  - `ramWEN=dWEN`; `ramREN=dREN&~dWEN` (write wins when both are set).
  - `ramaddr=daddr`; `ramstore=dstore`.
- `ARB_IXFER` drive: `ramREN=iREN`, `ramWEN=0`, `ramaddr=iaddr`, `ramstore=0`.
- In `ARB_IDLE`, all RAM outputs are 0.
- Completion:
  - While in XFER state, `ramstate==ACCESS` drops the granted wait low for that same cycle only.
  - Next state is `ARB_IDLE`.
- Error:
  - `ramstate==ERROR`, or the timeout counter reaching `TIMEOUT-1` while in XFER, ends the transfer.
  - `memerr=1` in the following cycle; next state is `ARB_IDLE`.
  - Wait stays high, so the requester retries by keeping its request asserted.
- Requester drops its request mid-transfer:
  - RAM strobes fall combinationally in the same cycle.
  - Next state is `ARB_IDLE`; no `memerr`.
- `iload=ramload` and `dload=ramload`, pass-through; valid only when the matching wait is low.
- Timeout counter:
  - Width `$clog2(TIMEOUT)`.
  - Cleared on entry to any XFER state.
  - Increments each XFER cycle without `ACCESS`/`ERROR`.

## Timing
- Reset values: state `ARB_IDLE`, `dstreak=0`, timer 0, `memerr=0`.
- Outputs at reset: `ramREN=ramWEN=0`, `ramaddr=ramstore=0`, `iwait=dwait=1`.
- Arbitration latency: request seen in `ARB_IDLE` at cycle n; RAM strobes asserted at n+1.
- Completion: `ACCESS` at cycle k gives wait low at k; state is `ARB_IDLE` at k+1. There is always one idle bubble between grants.
- Minimum transfer is 3 cycles from request to next grant opportunity (request, XFER with `ACCESS`, IDLE).
- Simultaneous I and D requests in `ARB_IDLE` go to D unless the streak limit is reached.
- `RST` high in any cycle, including mid-transfer, forces reset values at the next edge. RAM strobes are not guaranteed clean in the reset cycle itself.
- Waits are combinational from state and `ramstate`. No output is driven combinationally from `ramload` except the loads.

## Structure
- Add to the shared CPU types package:
  - `arbstate_t` (2-bit enum).
  - Default parameter constants `ARB_MAX_DSTREAK`, `ARB_TIMEOUT`.
- `ramstate_t` and `word_t` are reused from the package.
- The module is a single FSM with two counters. One natural sub-module is `arb_timer`, a clearable saturating timeout counter with a terminal-count output.

## Test plan
- Single D read: `dREN=1`, `daddr=0x40`; RAM `BUSY` 2 cycles then `ACCESS` with `ramload=0xDEADBEEF` -> `ramREN` high cycles 1-3; `dwait` low and `dload=0xDEADBEEF` at cycle 3; IDLE at 4.
- Both caches request at once, `dWEN=1`, `dREN=1` -> D granted first with `ramWEN=1`, `ramREN=0`; after completion and bubble, I granted.
- Starvation: D requests held continuously with `iREN=1`, RAM always `ACCESS` -> grant sequence D,D,D,D,I.
- Error and timeout:
  - `ramstate=ERROR` during `ARB_IXFER` -> `memerr` pulse 1 cycle, `iwait` stays high, re-grant after bubble.
  - Separately, RAM stuck `BUSY` for 64 cycles -> `memerr` pulse, grant released.
- Mid-transfer abort: `iREN` dropped during `BUSY` -> `ramREN=0` same cycle; IDLE next; `memerr=0`.
- Reset mid-transfer: `RST=1` during `ARB_DXFER` -> next cycle all RAM outputs 0, both waits 1, `dstreak=0`.
